three_input_gate_v_equation: RTL and testbench

THREE_INPUT_GATE_V_EQUATION -- requirements
Module: three_input_gate_v_equation

---
 rtl/three_input_gate_v_equation.sv | 47 ++++
 tb/tb_three_input_gate_v_equation.sv | 115 +++++++++++
 2 files changed

// File: rtl/three_input_gate_v_equation.sv
// 4-to-2 priority encoder with valid flag and registered outputs.
// Priority is expressed as flat sum-of-products equations selected by MSB_FIRST.
module three_input_gate_v_equation #(
   parameter int MSB_FIRST = 1
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [3:0] i_code,
   output logic [1:0] o_code,
   output logic       o_valid
);

   logic [1:0] w_code_nxt;
   logic       w_valid_nxt;
   logic [1:0] r_code;
   logic       r_valid;

   assign w_valid_nxt = i_code[3] | i_code[2] | i_code[1] | i_code[0];

   generate
      if (MSB_FIRST != 0) begin : g_msb_first
         assign w_code_nxt[1] = i_code[3] | i_code[2];
         assign w_code_nxt[0] = i_code[3] | (~i_code[2] & i_code[1]);
      end else begin : g_lsb_first
         // Raw LSB-first terms decode 4'b0000 as 3; folding in the valid term
         // keeps the all-zero input mapped to index 0.
         assign w_code_nxt[1] = (~i_code[0] & ~i_code[1] & i_code[2])
                              | (~i_code[0] & ~i_code[1] & i_code[3]);
         assign w_code_nxt[0] = (~i_code[0] & i_code[1])
                              | (~i_code[0] & ~i_code[2] & i_code[3]);
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_code  <= 2'b00;
         r_valid <= 1'b0;
      end else begin
         r_code  <= w_code_nxt;
         r_valid <= w_valid_nxt;
      end
   end

   assign o_code  = r_code;
   assign o_valid = r_valid;

endmodule

// File: tb/tb_three_input_gate_v_equation.sv
// Directed bench for both priority orders; expected values are {valid, code}.
module tb_three_input_gate_v_equation;

   logic       clk;
   logic       rst;
   logic [3:0] code;
   logic [1:0] msb_code, lsb_code;
   logic       msb_valid, lsb_valid;
   int         n_vec;
   int         n_err;

   three_input_gate_v_equation #(.MSB_FIRST(1)) u_msb (
      .i_clk(clk), .i_rst(rst), .i_code(code), .o_code(msb_code), .o_valid(msb_valid)
   );
   three_input_gate_v_equation #(.MSB_FIRST(0)) u_lsb (
      .i_clk(clk), .i_rst(rst), .i_code(code), .o_code(lsb_code), .o_valid(lsb_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] exp_msb(input logic [3:0] c);
      if (c == 4'd0)      return 3'b0_00;
      else if (c == 4'd1) return 3'b1_00;
      else if (c < 4'd4)  return 3'b1_01;
      else if (c < 4'd8)  return 3'b1_10;
      else                return 3'b1_11;
   endfunction

   function automatic logic [2:0] exp_lsb(input logic [3:0] c);
      for (int i = 0; i < 4; i++)
         if (c[i]) return {1'b1, 2'(i)};
      return 3'b0_00;
   endfunction

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic apply(input logic [3:0] c, input logic r);
      @(negedge clk);
      code = c;
      rst  = r;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [4:0] cnt;
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      code  = 4'bxxxx;

      // Unknown input under reset must still give clean zeros
      @(posedge clk);
      #1;
      chk("x_rst_msb", {msb_valid, msb_code}, 3'b0_00);
      chk("x_rst_lsb", {lsb_valid, lsb_code}, 3'b0_00);

      apply(4'b1000, 1'b1);
      chk("rst_hold_msb", {msb_valid, msb_code}, 3'b0_00);
      chk("rst_hold_lsb", {lsb_valid, lsb_code}, 3'b0_00);
      apply(4'b1000, 1'b0);
      chk("rst_rel_msb", {msb_valid, msb_code}, 3'b1_11);
      chk("rst_rel_lsb", {lsb_valid, lsb_code}, 3'b1_11);

      // Sweep with one mid-stream reset at value 9
      for (int v = 0; v < 16; v++) begin
         apply(4'(v), (v == 9));
         if (v == 9) begin
            chk("mid_rst_msb", {msb_valid, msb_code}, 3'b0_00);
            chk("mid_rst_lsb", {lsb_valid, lsb_code}, 3'b0_00);
            apply(4'(v), 1'b0);
         end
         chk($sformatf("sweep_msb_%0d", v), {msb_valid, msb_code}, exp_msb(4'(v)));
         chk($sformatf("sweep_lsb_%0d", v), {lsb_valid, lsb_code}, exp_lsb(4'(v)));
      end

      cnt = 5'd16;
      apply(cnt[3:0], 1'b0);
      chk("wrap16_msb", {msb_valid, msb_code}, 3'b0_00);
      cnt = 5'd17;
      apply(cnt[3:0], 1'b0);
      chk("wrap17_msb", {msb_valid, msb_code}, 3'b1_00);

      apply(4'b1100, 1'b0);
      chk("prio_1100_lsb", {lsb_valid, lsb_code}, 3'b1_10);
      chk("prio_1100_msb", {msb_valid, msb_code}, 3'b1_11);
      apply(4'b1010, 1'b0);
      chk("prio_1010_lsb", {lsb_valid, lsb_code}, 3'b1_01);
      apply(4'b0000, 1'b0);
      chk("zero_lsb", {lsb_valid, lsb_code}, 3'b0_00);

      apply(4'b0001, 1'b0);
      chk("lat_pre_msb", {msb_valid, msb_code}, 3'b1_00);
      @(negedge clk);
      code = 4'b0100;
      #1;
      chk("lat_hold_msb", {msb_valid, msb_code}, 3'b1_00);
      @(posedge clk);
      #1;
      chk("lat_post_msb", {msb_valid, msb_code}, 3'b1_10);
      chk("lat_post_lsb", {lsb_valid, lsb_code}, 3'b1_10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
